mehdi_pio_in: RTL and testbench
===============================

# mehdi_pio_in

Avalon-MM slave parallel input port, the input counterpart of the team's 8-bit output PIO. Samples an asynchronous external bus through a synchronizer and exposes its level on a 2-bit register map. Latches configured edges into a write-1-to-clear capture register and raises a maskable level interrupt toward the Nios II interrupt controller. Sits on the same system interconnect as the output PIO, with identical bus timing: zero-wait-state write, combinational readdata.

## Interface
- WIDTH, 8: number of input bits, 1..32.
- EDGE_TYPE, 0: capture condition; 0 = rising, 1 = falling, 2 = any edge.
- DEBOUNCE_CYCLES, 16: stability window in clk cycles; used only when the debounce macro is defined; minimum 1.
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset; one clock, async assert, active-low, no synchronous reset.
- address  in  2  word address of register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; write occurs when chipselect && !write_n.
- writedata  in  32  write data; bits above WIDTH ignored.
- in_port  in  WIDTH  external asynchronous inputs.
- readdata  out  32  combinational read data, zero-extended above WIDTH.
- irq  out  1  active-high level interrupt.

## Operation
- Register map:
  - 0 DATA: read-only, filtered input level; writes ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK: read/write, WIDTH bits.
  - 3 EDGECAPTURE: read; writing 1 to a bit clears it, writing 0 leaves it.
- Input path:
  - in_port passes through a 2-flop synchronizer (sync1, sync2).
  - The filtered value `level` is sync2, or the debounced value when debounce is compiled in.
  - `prev` holds `level` from the previous cycle.
- Edge detect, per bit:
  - rise = level & ~prev
  - fall = ~level & prev
  - Selected by EDGE_TYPE; any = rise | fall.
- Arm counter:
  - A 2-bit counter saturates at 3 after reset release.
  - Edge detection is gated off until it reaches 3, so an input already high at reset release is never captured as an edge.
- Capture:
  - EDGECAPTURE[i] sets on a detected edge and stays set until cleared by write-1.
  - If a clear and a set hit the same bit in the same cycle, the set wins and the bit stays 1.
- irq = |(EDGECAPTURE & IRQMASK), combinational from registers.
- Unused EDGE_TYPE values (3) behave as any-edge.

## Timing
- Reset: sync1, sync2, level, prev, IRQMASK, EDGECAPTURE and the arm counter are 0; readdata is 0 for every address; irq is 0.
- Read latency 0: readdata follows address combinationally and has no side effects.
- Writes take effect at the clock edge where the write strobe is sampled.
- Without debounce, for an in_port change set up before edge k:
  - sync1 updates at k; sync2 and DATA at k+1.
  - EDGECAPTURE bit set at k+2; irq high from k+2 if the bit is unmasked.
- Writing IRQMASK changes irq in the cycle after the write edge; no capture bits are lost.
- Clear write to EDGECAPTURE with no new edge: bit reads 0 and irq drops after the write edge.
- A pulse shorter than one clk period may be missed; this is not an error.
- Reset asserted mid-operation clears all state immediately. After release the arm counter restarts and edges are suppressed for 3 cycles.

## Configuration
- Macro: MEHDI_PIO_IN_DEBOUNCE_EN.
- Defined:
  - Each bit has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter increments while sync2 ≠ level and resets to 0 when they match.
  - When it reaches DEBOUNCE_CYCLES, `level` takes sync2 and the counter resets.
  - Adds DEBOUNCE_CYCLES cycles of latency to DATA, EDGECAPTURE and irq.
  - Glitches shorter than DEBOUNCE_CYCLES are rejected.
- Undefined: level = sync2, no counters, timing as stated above.

## Structure
- Package mehdi_pio_pkg:
  - Register address constants: ADDR_DATA = 0, ADDR_IRQMASK = 2, ADDR_EDGECAP = 3.
  - Edge-type constants: EDGE_RISE, EDGE_FALL, EDGE_ANY.
- Sub-module mehdi_pio_in_debounce: a single-bit debouncer parameterised by DEBOUNCE_CYCLES.
  - Instantiated WIDTH times in a generate loop.
  - Only present under MEHDI_PIO_IN_DEBOUNCE_EN.

## Test plan
- Reset with in_port = 8'hFF held → after 5 cycles DATA reads 0x000000FF, EDGECAPTURE reads 0, irq = 0 (arm gating).
- EDGE_TYPE = 0, IRQMASK = 0x01, in_port bit0 0→1 before edge k → DATA bit0 = 1 from k+1, EDGECAPTURE = 0x01 and irq = 1 from k+2.
- Write 0x01 to EDGECAPTURE while no new edge → reads 0x00 and irq = 0 after the write edge; a write of 0x00 leaves captured bits unchanged.
- Rising edge on bit3 in the same cycle as a clear-write of 0x08 → EDGECAPTURE bit3 remains 1 and irq stays asserted if masked in.
- EDGE_TYPE = 2, IRQMASK = 0x00, toggle bit7 twice → EDGECAPTURE = 0x80 and irq = 0; then write IRQMASK = 0x80 → irq = 1 next cycle; address 1 reads 0.
- With MEHDI_PIO_IN_DEBOUNCE_EN, DEBOUNCE_CYCLES = 4:
  - 3-cycle pulse on bit0 → DATA and EDGECAPTURE unchanged.
  - 6-cycle level on bit0 → DATA bit0 = 1 and EDGECAPTURE bit0 set 4 cycles later than in the non-debounce case.

Source files
------------

// File: rtl/mehdi_pio_pkg.sv
// mehdi_pio_pkg: shared constants for the parallel input port.
//   pio_addr_e : word addresses of the 2-bit register map
//   EDGE_*     : capture-condition encodings for the EDGE_TYPE parameter
//   ARM_DONE   : arm counter value at which edge detection is enabled
package mehdi_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_RSVD    = 2'd1,
        ADDR_IRQMASK = 2'd2,
        ADDR_EDGECAP = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam logic [1:0] ARM_DONE = 2'd3;

endpackage

// File: rtl/mehdi_pio_in_debounce.sv
// mehdi_pio_in_debounce: single-bit debouncer. The output follows the input
// only after the input has disagreed with it for DEBOUNCE_CYCLES consecutive
// cycles; shorter disagreements are dropped.
// Only compiled when MEHDI_PIO_IN_DEBOUNCE_EN is defined.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   din_i    in  synchronized input bit
//   level_o  out filtered level
`ifdef MEHDI_PIO_IN_DEBOUNCE_EN
module mehdi_pio_in_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_i,
    output logic level_o
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    // The update fires on the DEBOUNCE_CYCLES-th consecutive disagreeing
    // cycle, so exactly DEBOUNCE_CYCLES cycles of latency are added.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (din_i != level_q) begin
            if (cnt_q == CNT_LAST) level_d = din_i;
            else                   cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
endmodule
`endif

// File: rtl/mehdi_pio_in.sv
// mehdi_pio_in: Avalon-MM parallel input port with edge capture and a
// maskable level interrupt. Zero-wait writes, combinational readdata.
// Optional debounce filter: define MEHDI_PIO_IN_DEBOUNCE_EN.
//   clk, reset_n     clock, asynchronous active-low reset
//   address          word address (0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE)
//   chipselect       slave select
//   write_n          active-low write strobe
//   writedata        write data, bits above WIDTH ignored
//   in_port          asynchronous external inputs
//   readdata         combinational read data, zero-extended
//   irq              |(EDGECAPTURE & IRQMASK)
module mehdi_pio_in
    import mehdi_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] sync1_q, sync2_q, level, prev_q;
    logic [WIDTH-1:0] irqmask_q, irqmask_d, edgecap_q, edgecap_d;
    logic [WIDTH-1:0] rise, fall, edge_det, clr;
    logic [1:0]       arm_q, arm_d;
    logic             wr_en;

    // writedata bits above WIDTH have no destination.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

`ifdef MEHDI_PIO_IN_DEBOUNCE_EN
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
        mehdi_pio_in_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .din_i   (sync2_q[gi]),
            .level_o (level[gi])
        );
    end
`else
    localparam int UNUSED_DB_CYCLES = DEBOUNCE_CYCLES;
    assign level = sync2_q;
`endif

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        rise = level & ~prev_q;
        fall = ~level & prev_q;
        if (EDGE_TYPE == EDGE_RISE)      edge_det = rise;
        else if (EDGE_TYPE == EDGE_FALL) edge_det = fall;
        else                             edge_det = rise | fall;
        // Until armed, prev still holds reset zeros, so an input already
        // high at release would look like a rising edge.
        if (arm_q != ARM_DONE) edge_det = '0;
    end

    always_comb begin
        irqmask_d = irqmask_q;
        clr       = '0;
        if (wr_en && address == ADDR_IRQMASK) irqmask_d = writedata[WIDTH-1:0];
        if (wr_en && address == ADDR_EDGECAP) clr       = writedata[WIDTH-1:0];
        // A new edge on a bit being cleared in the same cycle survives.
        edgecap_d = (edgecap_q & ~clr) | edge_det;
        arm_d     = (arm_q == ARM_DONE) ? arm_q : arm_q + 2'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
            arm_q     <= '0;
        end else begin
            sync1_q   <= in_port;
            sync2_q   <= sync1_q;
            prev_q    <= level;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            arm_q     <= arm_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = level;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_mehdi_pio_in.sv
// tb_mehdi_pio_in: self-checking bench for mehdi_pio_in (WIDTH=8, rising edge).
// The reference model keeps the history of in_port values seen at each clock
// edge and derives level, edge capture, mask and irq from the documented
// latencies (level after edge e = input present at edge e-1-DB).
module tb_mehdi_pio_in;
    import mehdi_pio_pkg::*;

`ifdef MEHDI_PIO_IN_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif
    localparam int ET = 0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [7:0]  in_port = '0;
    logic [31:0] readdata;
    logic        irq;

    int errs = 0;
    int checks = 0;

    // model state
    logic [7:0] h[$];
    logic [7:0] m_ec = '0;
    logic [7:0] m_mask = '0;
    logic [7:0] cur_in = '0;

    mehdi_pio_in #(.WIDTH(8), .EDGE_TYPE(ET), .DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lv(int e);
        int i = e - 2 - DB;
        return (i >= 0) ? h[i] : 8'h00;
    endfunction

    function automatic logic m_irq();
        return |(m_ec & m_mask);
    endfunction

    task automatic model_reset();
        h.delete();
        m_ec   = '0;
        m_mask = '0;
    endtask

    // One clock edge: drive inputs at negedge, advance the model at posedge.
    task automatic tick(input logic [7:0] inp, input logic we,
                        input logic [1:0] a, input logic [31:0] wd);
        logic [7:0] c, p, set, cl;
        int e;
        @(negedge clk);
        in_port = inp; cur_in = inp;
        chipselect = we; write_n = !we; address = a; writedata = wd;
        @(posedge clk);
        h.push_back(inp);
        e = h.size();
        set = '0;
        if (e >= 4) begin
            c = lv(e - 1);
            p = lv(e - 2);
            if (ET == EDGE_RISE)      set = c & ~p;
            else if (ET == EDGE_FALL) set = ~c & p;
            else                      set = c ^ p;
        end
        cl = (we && a == 2'd3) ? wd[7:0] : 8'h00;
        m_ec = (m_ec & ~cl) | set;
        if (we && a == 2'd2) m_mask = wd[7:0];
        #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(cur_in, 1'b0, 2'd0, 32'h0);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0; in_port = 8'hFF; cur_in = 8'hFF;
        #1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            checks++;
            if (d !== 32'h0) begin errs++; $display("FAIL reset_rd%0d got %h exp 0", a, d); end
        end
        checks++;
        if (irq !== 1'b0) begin errs++; $display("FAIL reset_irq got %b exp 0", irq); end
        @(negedge clk); reset_n = 1'b1; model_reset();
        idle(5 + DB);
        rd(2'd0, d);
        checks++;
        if (d !== {24'h0, lv(h.size())}) begin errs++; $display("FAIL reset_data got %h exp %h", d, lv(h.size())); end
        rd(2'd3, d);
        checks++;
        if (d !== {24'h0, m_ec}) begin errs++; $display("FAIL reset_ec got %h exp %h", d, m_ec); end
        checks++;
        if (irq !== m_irq()) begin errs++; $display("FAIL reset_arm_irq got %b exp %b", irq, m_irq()); end
        // settle inputs low and start from a clean capture register
        tick(8'h00, 1'b0, 2'd0, 32'h0);
        idle(6 + DB);
        tick(8'h00, 1'b1, 2'd3, 32'hFF);
        tick(8'h00, 1'b1, 2'd2, 32'hFFFF_FF01);
    endtask

    task automatic test_rise();
        logic [31:0] d;
        tick(8'h01, 1'b0, 2'd0, 32'h0);
        for (int j = 1; j <= 3 + DB; j++) begin
            tick(8'h01, 1'b0, 2'd0, 32'h0);
            rd(2'd0, d);
            checks++;
            if (d !== {24'h0, lv(h.size())}) begin errs++; $display("FAIL rise_data j=%0d got %h exp %h", j, d, lv(h.size())); end
            rd(2'd3, d);
            checks++;
            if (d !== {24'h0, m_ec}) begin errs++; $display("FAIL rise_ec j=%0d got %h exp %h", j, d, m_ec); end
            checks++;
            if (irq !== m_irq()) begin errs++; $display("FAIL rise_irq j=%0d got %b exp %b", j, irq, m_irq()); end
        end
    endtask

    task automatic test_clear();
        logic [31:0] d;
        tick(8'h01, 1'b1, 2'd3, 32'h1);
        rd(2'd3, d);
        checks++;
        if (d !== {24'h0, m_ec}) begin errs++; $display("FAIL clear_ec got %h exp %h", d, m_ec); end
        checks++;
        if (irq !== m_irq()) begin errs++; $display("FAIL clear_irq got %b exp %b", irq, m_irq()); end
        tick(8'h03, 1'b0, 2'd0, 32'h0);
        idle(3 + DB);
        tick(8'h03, 1'b1, 2'd3, 32'h0);
        rd(2'd3, d);
        checks++;
        if (d !== {24'h0, m_ec}) begin errs++; $display("FAIL clear_zero_ec got %h exp %h", d, m_ec); end
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        tick(8'h03, 1'b1, 2'd2, 32'h08);
        tick(8'h0B, 1'b0, 2'd0, 32'h0);
        idle(1 + DB);
        tick(8'h0B, 1'b1, 2'd3, 32'h08);
        rd(2'd3, d);
        checks++;
        if (d[3] !== 1'b1 || d !== {24'h0, m_ec}) begin errs++; $display("FAIL setwins_ec got %h exp %h", d, m_ec); end
        checks++;
        if (irq !== 1'b1) begin errs++; $display("FAIL setwins_irq got %b exp 1", irq); end
    endtask

    task automatic test_mask_late();
        logic [31:0] d;
        tick(8'h0B, 1'b1, 2'd2, 32'h00);
        tick(8'h0B, 1'b1, 2'd3, 32'hFF);
        tick(8'h8B, 1'b0, 2'd0, 32'h0);
        idle(3 + DB);
        tick(8'h0B, 1'b0, 2'd0, 32'h0);
        idle(3 + DB);
        rd(2'd3, d);
        checks++;
        if (d !== {24'h0, m_ec} || d !== 32'h80) begin errs++; $display("FAIL bit7_ec got %h exp %h", d, m_ec); end
        checks++;
        if (irq !== 1'b0) begin errs++; $display("FAIL bit7_irq_masked got %b exp 0", irq); end
        tick(8'h0B, 1'b1, 2'd2, 32'h80);
        checks++;
        if (irq !== 1'b1) begin errs++; $display("FAIL bit7_irq_unmasked got %b exp 1", irq); end
        rd(2'd1, d);
        checks++;
        if (d !== 32'h0) begin errs++; $display("FAIL rsvd_rd got %h exp 0", d); end
        rd(2'd2, d);
        checks++;
        if (d !== {24'h0, m_mask}) begin errs++; $display("FAIL mask_rd got %h exp %h", d, m_mask); end
    endtask

    task automatic test_random();
        logic [31:0] d, wd;
        logic [7:0]  v;
        int          op;
        for (int it = 0; it < 40; it++) begin
            v  = 8'($urandom);
            wd = $urandom;
            op = $urandom_range(0, 3);
            for (int j = 0; j < DB + 2; j++) begin
                if (j == 0 && op != 0)
                    tick(v, 1'b1, (op == 1) ? 2'd2 : (op == 2) ? 2'd3 : 2'($urandom_range(0, 1)), wd);
                else
                    tick(v, 1'b0, 2'd0, 32'h0);
                rd(2'd0, d);
                checks++;
                if (d !== {24'h0, lv(h.size())}) begin errs++; $display("FAIL rnd_data it=%0d got %h exp %h", it, d, lv(h.size())); end
                rd(2'd3, d);
                checks++;
                if (d !== {24'h0, m_ec}) begin errs++; $display("FAIL rnd_ec it=%0d got %h exp %h", it, d, m_ec); end
                rd(2'd2, d);
                checks++;
                if (d !== {24'h0, m_mask}) begin errs++; $display("FAIL rnd_mask it=%0d got %h exp %h", it, d, m_mask); end
                checks++;
                if (irq !== m_irq()) begin errs++; $display("FAIL rnd_irq it=%0d got %b exp %b", it, irq, m_irq()); end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] d;
        tick(8'hFF, 1'b1, 2'd2, 32'hFF);
        idle(4 + DB);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        rd(2'd2, d);
        checks++;
        if (d !== 32'h0) begin errs++; $display("FAIL midrst_mask got %h exp 0", d); end
        rd(2'd3, d);
        checks++;
        if (d !== 32'h0) begin errs++; $display("FAIL midrst_ec got %h exp 0", d); end
        checks++;
        if (irq !== 1'b0) begin errs++; $display("FAIL midrst_irq got %b exp 0", irq); end
        @(negedge clk); reset_n = 1'b1; model_reset();
        idle(6 + DB);
        rd(2'd3, d);
        checks++;
        if (d !== {24'h0, m_ec}) begin errs++; $display("FAIL midrst_rearm_ec got %h exp %h", d, m_ec); end
    endtask

`ifdef MEHDI_PIO_IN_DEBOUNCE_EN
    task automatic test_debounce();
        logic [31:0] d;
        tick(8'h00, 1'b0, 2'd0, 32'h0);
        idle(12);
        tick(8'h00, 1'b1, 2'd3, 32'hFF);
        for (int j = 0; j < 3; j++) tick(8'h01, 1'b0, 2'd0, 32'h0);
        for (int j = 0; j < 12; j++) tick(8'h00, 1'b0, 2'd0, 32'h0);
        rd(2'd0, d);
        checks++;
        if (d !== 32'h0) begin errs++; $display("FAIL db_glitch_data got %h exp 0", d); end
        rd(2'd3, d);
        checks++;
        if (d !== 32'h0) begin errs++; $display("FAIL db_glitch_ec got %h exp 0", d); end
        tick(8'h01, 1'b0, 2'd0, 32'h0);
        for (int j = 1; j <= 7; j++) begin
            tick((j < 6) ? 8'h01 : 8'h00, 1'b0, 2'd0, 32'h0);
            rd(2'd0, d);
            if (j == 4 || j == 5) begin
                checks++;
                if (d[0] !== (j == 5)) begin errs++; $display("FAIL db_data j=%0d got %h", j, d); end
            end
            rd(2'd3, d);
            if (j == 5 || j == 6) begin
                checks++;
                if (d[0] !== (j == 6)) begin errs++; $display("FAIL db_ec j=%0d got %h", j, d); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rise();
        test_clear();
        test_set_wins();
        test_mask_late();
        test_random();
        test_mid_reset();
`ifdef MEHDI_PIO_IN_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
